regfile_wb_arbiter: RTL and testbench

//  Write-back side of the RV32I register file: sole driver of its write port (a3/wd3/we3).

---
 rtl/regfile_wb_arbiter_if.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the EX/MEM result paths, decode's issue tracking and the
// register-file write port, as seen by the write-back arbiter.
//
// Handshake rules, in one place:
//  - ALU beat: alu_valid_i qualifies alu_rd_i/alu_data_i. There is no ready,
//    so every beat is taken on the edge where it is presented.
//  - LSU beat: a transfer happens on a rising clk_rf edge where
//    lsu_valid_i & lsu_ready_o are both high. lsu_ready_o depends only on FIFO
//    occupancy and never on lsu_valid_i. A source holds rd/data stable while
//    valid is high and ready is low.
//  - Issue: issue_valid_i qualifies issue_rd_i for one edge (no ready).
//  - Write port: we3_rf qualifies a3_rf/wd3_rf for exactly one cycle per write.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid_i;
  logic [4:0]      alu_rd_i;
  logic [XLEN-1:0] alu_data_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic [4:0]      lsu_rd_i;
  logic [XLEN-1:0] lsu_data_i;
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic [31:0]     busy_o;
  logic [4:0]      a3_rf;
  logic [XLEN-1:0] wd3_rf;
  logic            we3_rf;

  // Upstream side: result producers, decode and observers of the write port.
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_valid_i, issue_rd_i,
    input  lsu_ready_o, busy_o, a3_rf, wd3_rf, we3_rf
  );

  // Arbiter side.
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_valid_i, issue_rd_i,
    output lsu_ready_o, busy_o, a3_rf, wd3_rf, we3_rf
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the RV32I register file. Single-cycle ALU results
// always win the write port; load results wait in a small in-order FIFO and
// drain in cycles with no ALU write. A per-register pending bit lets decode
// stall on RAW hazards until the producing write has been registered.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_rf,
  input  logic                 rst_rf,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Load-result FIFO storage and pointers.
  logic [4:0]      mem_rd_q   [FIFO_DEPTH];
  logic [4:0]      mem_rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Registered write port and pending-write scoreboard.
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            we3_q, we3_d;
  logic [31:0]     busy_q, busy_d;

  // Per-cycle decisions.
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            alu_sel;
  logic            wr_sel;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // Ready comes from occupancy alone; a freshly pushed entry is only visible
  // through count_q, so it cannot be popped on the edge that wrote it.
  always_comb begin
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // Loads to x0 are handshaked like any other beat but never stored.
    push       = bus.lsu_valid_i && !fifo_full && (bus.lsu_rd_i != 5'd0);
    alu_sel    = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    pop        = !alu_sel && !fifo_empty;
    wr_sel     = alu_sel || pop;
    sel_rd     = alu_sel ? bus.alu_rd_i   : mem_rd_q[rd_ptr_q];
    sel_data   = alu_sel ? bus.alu_data_i : mem_data_q[rd_ptr_q];
  end

  // FIFO next state: storage write, pointer wrap, occupancy update.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = bus.lsu_rd_i;
      mem_data_d[wr_ptr_q] = bus.lsu_data_i;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write port and scoreboard next state; a new issue to rd overrides the
  // clear from a write to the same rd because it names a newer producer.
  always_comb begin
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    we3_d  = wr_sel;
    busy_d = busy_q;
    if (wr_sel) begin
      a3_d           = sel_rd;
      wd3_d          = sel_data;
      busy_d[sel_rd] = 1'b0;
    end
    if (bus.issue_valid_i && (bus.issue_rd_i != 5'd0)) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers, all cleared asynchronously by rst_rf.
  always_ff @(posedge clk_rf or negedge rst_rf) begin
    if (!rst_rf) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      we3_q      <= we3_d;
      busy_q     <= busy_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.lsu_ready_o = !fifo_full;
    bus.busy_o      = busy_q;
    bus.a3_rf       = a3_q;
    bus.wd3_rf      = wd3_q;
    bus.we3_rf      = we3_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter. Drivers push the expected
// register writes into a queue in hand-computed commit order; a monitor pops
// and compares on every cycle where we3_rf is high.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int W    = 5 + XLEN;

  logic clk_rf;
  logic rst_rf;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(4)) dut (
    .clk_rf (clk_rf),
    .rst_rf (rst_rf),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk_rf = 1'b0;
  always #5 clk_rf = ~clk_rf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / drivers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk_rf);
    #1;
  endtask

  task automatic drive_idle();
    bus.alu_valid_i   = 1'b0;
    bus.alu_rd_i      = 5'd0;
    bus.alu_data_i    = '0;
    bus.lsu_valid_i   = 1'b0;
    bus.lsu_rd_i      = 5'd0;
    bus.lsu_data_i    = '0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = rd;
    bus.alu_data_i  = data;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [XLEN-1:0] data);
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = rd;
    bus.lsu_data_i  = data;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [XLEN-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_rf) begin
    if (rst_rf && bus.we3_rf) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%0h expected no write at %0t",
                 bus.a3_rf, bus.wd3_rf, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({bus.a3_rf, bus.wd3_rf} !== e) begin
          errors++;
          $display("FAIL write_port: got x%0d=0x%0h expected x%0d=0x%0h at %0t",
                   bus.a3_rf, bus.wd3_rf, e[W-1:XLEN], e[XLEN-1:0], $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_rf = 1'b0;
    drive_idle();

    // 1. Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid_i   = 1'($urandom_range(0, 1));
      bus.alu_rd_i      = 5'($urandom_range(0, 31));
      bus.alu_data_i    = $urandom;
      bus.lsu_valid_i   = 1'($urandom_range(0, 1));
      bus.lsu_rd_i      = 5'($urandom_range(0, 31));
      bus.lsu_data_i    = $urandom;
      bus.issue_valid_i = 1'($urandom_range(0, 1));
      bus.issue_rd_i    = 5'($urandom_range(0, 31));
      cycle();
    end
    check("rst_we3", 64'(bus.we3_rf), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_ready", 64'(bus.lsu_ready_o), 64'd1);
    check("rst_a3", 64'(bus.a3_rf), 64'd0);
    drive_idle();
    rst_rf = 1'b1;
    cycle();
    cycle();
    check("post_rst_we3", 64'(bus.we3_rf), 64'd0);
    check("post_rst_wd3", 64'(bus.wd3_rf), 64'd0);
    check("post_rst_busy", 64'(bus.busy_o), 64'd0);

    // 2. Single ALU write, then port idles holding address/data.
    alu(5'd5, 32'hDEADBEEF);
    expect_write(5'd5, 32'hDEADBEEF);
    cycle();
    drive_idle();
    check("alu_we3", 64'(bus.we3_rf), 64'd1);
    check("alu_a3", 64'(bus.a3_rf), 64'd5);
    cycle();
    check("alu_we3_drop", 64'(bus.we3_rf), 64'd0);
    check("alu_a3_hold", 64'(bus.a3_rf), 64'd5);
    check("alu_wd3_hold", 64'(bus.wd3_rf), 64'hDEADBEEF);

    // 3. LSU beat waits behind three ALU writes.
    alu(5'd1, 32'h0000_0101);
    lsu(5'd7, 32'h0000_0011);
    expect_write(5'd1, 32'h0000_0101);
    cycle();
    bus.lsu_valid_i = 1'b0;
    alu(5'd2, 32'h0000_0202);
    expect_write(5'd2, 32'h0000_0202);
    cycle();
    alu(5'd3, 32'h0000_0303);
    expect_write(5'd3, 32'h0000_0303);
    cycle();
    check("arb_a3_x3", 64'(bus.a3_rf), 64'd3);
    drive_idle();
    expect_write(5'd7, 32'h0000_0011);
    cycle();
    check("arb_a3_x7", 64'(bus.a3_rf), 64'd7);
    check("arb_wd3_x7", 64'(bus.wd3_rf), 64'h11);
    cycle();

    // 4. Fill the FIFO under a saturating ALU stream, then drain in order.
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 64'(bus.lsu_ready_o), 64'd1);
      alu(5'(10 + i), 32'hC000_0000 + 32'(i));
      lsu(5'(12 + i), 32'hA0 + 32'(i));
      expect_write(5'(10 + i), 32'hC000_0000 + 32'(i));
      cycle();
    end
    check("full_ready", 64'(bus.lsu_ready_o), 64'd0);
    // Beat offered while full must not be taken.
    alu(5'd20, 32'hC000_0004);
    lsu(5'd21, 32'hBAD);
    expect_write(5'd20, 32'hC000_0004);
    cycle();
    check("full_ready_hold", 64'(bus.lsu_ready_o), 64'd0);
    drive_idle();
    for (int i = 0; i < 4; i++) expect_write(5'(12 + i), 32'hA0 + 32'(i));
    cycle();
    check("drain_ready", 64'(bus.lsu_ready_o), 64'd1);
    check("drain_first", 64'(bus.a3_rf), 64'd12);
    cycle();
    cycle();
    cycle();
    check("drain_last", 64'(bus.a3_rf), 64'd15);
    cycle();
    check("drain_idle", 64'(bus.we3_rf), 64'd0);

    // 5. Scoreboard set, clear, and set-wins-over-clear.
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd9;
    cycle();
    drive_idle();
    check("sb_set", 64'(bus.busy_o), 64'h0000_0200);
    alu(5'd9, 32'h99);
    expect_write(5'd9, 32'h99);
    cycle();
    drive_idle();
    check("sb_clear", 64'(bus.busy_o), 64'd0);
    alu(5'd9, 32'h9A);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd9;
    expect_write(5'd9, 32'h9A);
    cycle();
    drive_idle();
    check("sb_set_wins", 64'(bus.busy_o), 64'h0000_0200);
    alu(5'd9, 32'h9B);
    expect_write(5'd9, 32'h9B);
    cycle();
    drive_idle();
    check("sb_clear2", 64'(bus.busy_o), 64'd0);

    // 6a. x0 traffic: nothing written, nothing queued, x0 never busy.
    alu(5'd0, 32'h1234);
    lsu(5'd0, 32'h5678);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd0;
    cycle();
    drive_idle();
    check("x0_we3", 64'(bus.we3_rf), 64'd0);
    check("x0_busy", 64'(bus.busy_o), 64'd0);
    cycle();
    check("x0_no_fifo", 64'(bus.we3_rf), 64'd0);

    // 6b. Reset with three loads queued behind ALU writes.
    for (int i = 0; i < 3; i++) begin
      alu(5'(1 + i), 32'hE0 + 32'(i));
      lsu(5'(4 + i), 32'hF0 + 32'(i));
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i    = 5'(4 + i);
      expect_write(5'(1 + i), 32'hE0 + 32'(i));
      cycle();
    end
    drive_idle();
    alu(5'd0, 32'h0);
    check("pre_rst_busy", 64'(bus.busy_o), 64'h0000_0070);
    @(negedge clk_rf);
    #1;
    rst_rf = 1'b0;
    #1;
    check("mid_rst_we3", 64'(bus.we3_rf), 64'd0);
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_ready", 64'(bus.lsu_ready_o), 64'd1);
    drive_idle();
    cycle();
    rst_rf = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("post_mid_rst_we3", 64'(bus.we3_rf), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
